// File: rtl/bcrypt_pkg.sv
// Shared definitions for the S-box read controller: FSM states, bank geometry
// and the half-block to SRAM read-address packing.
package bcrypt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CALC1 = 3'd3,
        CALC2 = 3'd4,
        HOLD  = 3'd5
    } sbox_rd_state_e;

    localparam int SBOX_BANKS = 4;
    localparam int SBOX_ROW_W = 64;

    // a=x[31:24] goes to bank 0 in the lowest byte, d=x[7:0] to bank 3 in the top byte.
    function automatic logic [31:0] byte_to_addr(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sbox_f_pipe.sv
// Two-stage Blowfish F combiner: stage 0 adds S0+S1, stage 1 xors S2 and adds S3.
module sbox_f_pipe (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [1:0]  stage_en,
    input  logic [31:0] s0,
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [31:0] s3,
    output logic [31:0] f_out
);

    logic [31:0] t_reg;
    logic [31:0] f_reg;

    // Each stage only loads on its own enable so f_out stays put while the FSM holds.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            t_reg <= '0;
            f_reg <= '0;
        end else begin
            if (stage_en[0]) t_reg <= s0 + s1;
            if (stage_en[1]) f_reg <= (t_reg ^ s2) + s3;
        end
    end

    assign f_out = f_reg;

endmodule

// File: rtl/sbox_read_ctrl.sv
// Reads the four S-box banks for one half-block x and returns the Blowfish F(x),
// with a bounded wait on the SRAM and a sticky timeout flag.
module sbox_read_ctrl
    import bcrypt_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    output logic [31:0] re_addr,
    output logic        rd_req,
    input  logic        data_ready,
    input  logic [63:0] rd_data_0,
    input  logic [63:0] rd_data_1,
    input  logic [63:0] rd_data_2,
    input  logic [63:0] rd_data_3,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_out,
    output logic        rd_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    sbox_rd_state_e                          state_reg, state_next;
    logic [CNT_W-1:0]                        cnt_reg;
    logic [31:0]                             re_addr_reg;
    logic                                    rd_err_reg;
    logic [SBOX_BANKS-1:0][31:0]             s_reg;
    logic [SBOX_BANKS-1:0][31:0]             sel_word;
    logic [SBOX_BANKS-1:0][SBOX_ROW_W-1:0]   row;
    logic                                    accept;
    logic                                    in_wait;
    logic                                    timeout_hit;

    assign row = {rd_data_3, rd_data_2, rd_data_1, rd_data_0};

    // Bit 0 of each bank's address byte picks which 32-bit entry of the row is wanted.
    generate
        for (genvar gi = 0; gi < SBOX_BANKS; gi++) begin : g_bank
            assign sel_word[gi] = re_addr_reg[8*gi] ? row[gi][SBOX_ROW_W-1:32]
                                                    : row[gi][31:0];
        end
    endgenerate

    assign accept      = (state_reg == IDLE) && req_valid;
    assign in_wait     = (state_reg == WAIT);
    assign timeout_hit = (TIMEOUT != 0) && ((cnt_reg + CNT_W'(1)) == CNT_W'(TIMEOUT));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                // data_ready takes priority over a coincident timeout.
                if (data_ready)       state_next = CALC1;
                else if (timeout_hit) state_next = IDLE;
            end
            CALC1:   state_next = CALC2;
            CALC2:   state_next = HOLD;
            HOLD:    if (f_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            re_addr_reg <= '0;
            rd_err_reg  <= 1'b0;
            s_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                re_addr_reg <= byte_to_addr(req_x);
                rd_err_reg  <= 1'b0;
            end
            if (in_wait) begin
                if (data_ready) begin
                    s_reg   <= sel_word;
                    cnt_reg <= '0;
                end else if (timeout_hit) begin
                    rd_err_reg <= 1'b1;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    sbox_f_pipe u_f_pipe (
        .clk      (clk),
        .rst_l    (rst_l),
        .stage_en ({state_reg == CALC2, state_reg == CALC1}),
        .s0       (s_reg[0]),
        .s1       (s_reg[1]),
        .s2       (s_reg[2]),
        .s3       (s_reg[3]),
        .f_out    (f_out)
    );

    assign req_ready = (state_reg == IDLE);
    assign rd_req    = (state_reg == ISSUE) || (state_reg == WAIT);
    assign f_valid   = (state_reg == HOLD);
    assign re_addr   = re_addr_reg;
    assign rd_err    = rd_err_reg;

endmodule

// File: tb/tb_sbox_read_ctrl.sv
// Directed bench for sbox_read_ctrl: hand-computed F values, backpressure,
// timeout, early data_ready and reset in the middle of a read.
module tb_sbox_read_ctrl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] re_addr;
    logic        rd_req;
    logic        data_ready = 1'b0;
    logic [63:0] rd_data_0 = '0;
    logic [63:0] rd_data_1 = '0;
    logic [63:0] rd_data_2 = '0;
    logic [63:0] rd_data_3 = '0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_out;
    logic        rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sbox_read_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .re_addr    (re_addr),
        .rd_req     (rd_req),
        .data_ready (data_ready),
        .rd_data_0  (rd_data_0),
        .rd_data_1  (rd_data_1),
        .rd_data_2  (rd_data_2),
        .rd_data_3  (rd_data_3),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_out      (f_out),
        .rd_err     (rd_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the ISSUE cycle.
    task automatic start_req(input logic [31:0] x);
        req_x     = x;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_hold(input string tag, input logic [31:0] exp_addr,
                               input logic [31:0] exp_f, input int stall);
        int k;
        k = 0;
        while (!f_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "/f_valid"}, 32'(f_valid), 32'd1);
        check_val({tag, "/f_out"}, f_out, exp_f);
        for (int i = 0; i < stall; i++) begin
            if (i == 2) begin
                req_x     = 32'h5A5A5A5A;
                req_valid = 1'b1;
            end
            @(negedge clk);
            req_valid = 1'b0;
            check_val({tag, "/hold_valid"}, 32'(f_valid), 32'd1);
            check_val({tag, "/hold_f_out"}, f_out, exp_f);
            check_val({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
            check_val({tag, "/hold_re_addr"}, re_addr, exp_addr);
        end
        f_ready = 1'b1;
        @(negedge clk);
        f_ready = 1'b0;
        check_val({tag, "/idle_req_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, "/idle_f_valid"}, 32'(f_valid), 32'd0);
    endtask

    task automatic run_read(input string tag, input logic [31:0] x, input logic [31:0] exp_addr,
                            input logic [63:0] r0, input logic [63:0] r1,
                            input logic [63:0] r2, input logic [63:0] r3,
                            input logic [31:0] exp_f, input int stall, input bit early);
        start_req(x);
        check_val({tag, "/issue_rd_req"}, 32'(rd_req), 32'd1);
        check_val({tag, "/issue_req_ready"}, 32'(req_ready), 32'd0);
        check_val({tag, "/re_addr"}, re_addr, exp_addr);
        check_val({tag, "/rd_err_clr"}, 32'(rd_err), 32'd0);
        if (early) begin
            rd_data_0  = 64'hDEADBEEF_CAFEF00D;
            rd_data_1  = 64'hDEADBEEF_CAFEF00D;
            rd_data_2  = 64'hDEADBEEF_CAFEF00D;
            rd_data_3  = 64'hDEADBEEF_CAFEF00D;
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            @(negedge clk);
            check_val({tag, "/early_ignored_rd_req"}, 32'(rd_req), 32'd1);
            check_val({tag, "/early_ignored_f_valid"}, 32'(f_valid), 32'd0);
        end else begin
            @(negedge clk);
        end
        rd_data_0  = r0;
        rd_data_1  = r1;
        rd_data_2  = r2;
        rd_data_3  = r3;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check_val({tag, "/captured_rd_req"}, 32'(rd_req), 32'd0);
        finish_hold(tag, exp_addr, exp_f, stall);
        $display("txn %s x=0x%08h re_addr=0x%08h f_out=0x%08h", tag, x, exp_addr, exp_f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;

        repeat (2) @(negedge clk);
        check_val("rst/req_ready", 32'(req_ready), 32'd1);
        check_val("rst/rd_req", 32'(rd_req), 32'd0);
        check_val("rst/f_valid", 32'(f_valid), 32'd0);
        check_val("rst/f_out", f_out, 32'h0);
        check_val("rst/re_addr", re_addr, 32'h0);
        check_val("rst/rd_err", 32'(rd_err), 32'd0);
        $display("txn reset released");
        rst_l = 1'b1;
        @(negedge clk);

        // Lower halves: 2+2=4, 4^2=6, 6+2=8.
        run_read("T1", 32'h00000000, 32'h00000000,
                 {32'h1, 32'h2}, {32'h1, 32'h2}, {32'h1, 32'h2}, {32'h1, 32'h2},
                 32'h00000008, 0, 1'b0);

        // Upper halves: t=FFFFFFFE, ^FFFFFFFF=1, +FFFFFFFF wraps to 0.
        run_read("T2", 32'h01010101, 32'h01010101,
                 {32'hFFFFFFFF, 32'h0}, {32'hFFFFFFFF, 32'h0},
                 {32'hFFFFFFFF, 32'h0}, {32'hFFFFFFFF, 32'h0},
                 32'h00000000, 0, 1'b0);

        // Mixed halves, distinct banks, 5 stall cycles: s=10,22,0F0F0F0F,100 -> 0F0F103D.
        run_read("T3", 32'h01000100, 32'h00010001,
                 {32'h10, 32'h11}, {32'h20, 32'h22},
                 {32'h0F0F0F0F, 32'h5}, {32'h7, 32'h100},
                 32'h0F0F103D, 5, 1'b0);

        // Timeout: 15 WAIT cycles without data_ready.
        start_req(32'hAABBCCDD);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen_valid |= f_valid;
        end
        check_val("T4/wait15_rd_req", 32'(rd_req), 32'd1);
        check_val("T4/wait15_rd_err", 32'(rd_err), 32'd0);
        @(negedge clk);
        check_val("T4/rd_err", 32'(rd_err), 32'd1);
        check_val("T4/rd_req", 32'(rd_req), 32'd0);
        check_val("T4/req_ready", 32'(req_ready), 32'd1);
        check_val("T4/no_f_valid", 32'(seen_valid | f_valid), 32'd0);
        check_val("T4/re_addr_kept", re_addr, 32'hDDCCBBAA);
        @(negedge clk);
        check_val("T4/rd_err_sticky", 32'(rd_err), 32'd1);
        $display("txn T4 x=0xaabbccdd timeout rd_err=%0d", rd_err);

        // Early data_ready in ISSUE; s=3,4,1,10 -> (7^1)+10 = 16.
        run_read("T5", 32'h80402001, 32'h01204080,
                 {32'h0, 32'h3}, {32'h0, 32'h4}, {32'h0, 32'h1}, {32'h10, 32'h0},
                 32'h00000016, 0, 1'b1);

        // Reset asserted in WAIT.
        start_req(32'h12345678);
        @(negedge clk);
        check_val("T6/in_wait", 32'(rd_req), 32'd1);
        rst_l = 1'b0;
        #1;
        check_val("T6/req_ready", 32'(req_ready), 32'd1);
        check_val("T6/rd_req", 32'(rd_req), 32'd0);
        check_val("T6/re_addr", re_addr, 32'h0);
        check_val("T6/f_out", f_out, 32'h0);
        check_val("T6/f_valid", 32'(f_valid), 32'd0);
        check_val("T6/rd_err", 32'(rd_err), 32'd0);
        $display("txn T6 reset in WAIT");
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        run_read("T6b", 32'h00000000, 32'h00000000,
                 {32'h1, 32'h2}, {32'h1, 32'h2}, {32'h1, 32'h2}, {32'h1, 32'h2},
                 32'h00000008, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
